uart_pack: RTL and testbench
============================

# uart_pack

Packet builder for the UART host link. It serialises the current scaler parameters into a framed byte stream: 0x00 header, type byte, payload, then 0xFF 0x00 tail. This is the same framing the host uses toward the FPGA, so a packet emitted here can be decoded by the existing command parser. The block sits between the parameter/status registers and the byte-level UART transmitter, and hands over one byte at a time with a valid/ready handshake.

## Interface
Parameters:
- GAP_CYCLES, 0, number of idle cycles with tx_valid low inserted after every accepted byte except the last byte of a packet.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pkt_req  in  1  request to send a packet. Sampled only while busy=0.
- pkt_type  in  4  packet type. 0 = crop window, 1 = output size, any other value = crop-window layout.
- start_x, start_y, end_x, end_y  in  16 each  crop window fields, big-endian on the wire.
- size_x, size_y  in  16 each  output size fields, big-endian on the wire.
- algorithm  in  8  scaling algorithm code.
- tx_ready  in  1  the UART transmitter can accept a byte.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  8  byte to send.
- busy  out  1  a packet is in progress.
- pkt_done  out  1  one-cycle pulse after the final tail byte is accepted.

## Operation
- **Reset values:** tx_valid=0, tx_data=0x00, busy=0, pkt_done=0, state=IDLE. All payload snapshot registers are 0.
- **Handshake:** a byte transfers on a clock edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold their values.
  - tx_valid never depends combinationally on tx_ready.
- **Accept:** in IDLE, when pkt_req=1, the block latches pkt_type and all field inputs into a snapshot. Later changes to the inputs do not affect the packet in flight. pkt_req while busy=1 is ignored; there is no queue.
- **States:** IDLE → HD0 (0x00) → HD1 ({4'h0, pkt_type}) → DATA (payload bytes) → END0 (0xFF) → END1 (0x00) → IDLE.
  - Each state advances on a handshake of its byte.
  - DATA uses a byte counter that runs from 1 to the payload length L.
- **Payload, type 0 and types ≥2 (L=9):** start_x[15:8], start_x[7:0], start_y hi, start_y lo, end_x hi, end_x lo, end_y hi, end_y lo, algorithm.
- **Payload, type 1 (L=5):** size_x hi, size_x lo, size_y hi, size_y lo, algorithm.
- **Type byte:** the transmitted type byte is always {4'h0, pkt_type}, including for types ≥2.
- **Gap:** when GAP_CYCLES>0, a handshake of any byte except END1 is followed by GAP_CYCLES cycles with tx_valid=0. The next byte is presented after that. A down-counter that saturates at 0 implements the gap.
- **Completion:** the handshake of END1 returns the block to IDLE. In the next cycle busy=0 and pkt_done=1. A pkt_req in that cycle is accepted.
- **Reset during a packet:** tx_valid drops to 0 immediately, without waiting for the clock. The stream is truncated and pkt_done is not pulsed. The far-end parser recovers through its own inter-byte timeout.

## Timing
- Accept edge at cycle N. From cycle N+1: busy=1, tx_valid=1, tx_data=0x00.
- With tx_ready held at 1 and GAP_CYCLES=0, one byte transfers per cycle.
  - Type 0: 13 bytes occupy cycles N+1 to N+13, and pkt_done=1 at N+14.
  - Type 1: 9 bytes occupy cycles N+1 to N+9, and pkt_done=1 at N+10.
- With a gap, total packet length in cycles = bytes + (bytes−1)·GAP_CYCLES, plus any cycles where tx_ready=0.
- busy is 1 from N+1 through the cycle of the END1 handshake, and 0 in the pkt_done cycle.

## Test plan
- **Type 0 packet:** pkt_type=0, start_x=0x0010, start_y=0x0020, end_x=0x0780, end_y=0x0438, algorithm=0x02, tx_ready=1. Required stream: 00 00 00 10 00 20 07 80 04 38 02 FF 00. pkt_done is 1 at N+14.
- **Type 1 packet:** pkt_type=1, size_x=0x0500, size_y=0x02D0, algorithm=0x01. Required stream: 00 01 05 00 02 D0 01 FF 00, 9 bytes in total.
- **Backpressure:** type 0 with tx_ready randomly 0 about 50% of the time. The stream is identical to the first test, and tx_data holds stable during every stall.
- **Snapshot and ignored requests:** change start_x and pulse pkt_req mid-packet. The in-flight bytes are unchanged and exactly one packet is sent. A pkt_req in the pkt_done cycle starts a second packet with 0x00 on the next cycle.
- **Gap:** GAP_CYCLES=3 with type 1. There are 3 low cycles between consecutive bytes and no gap after END1, so the packet spans 9+8·3=33 cycles.
- **Reset mid-packet:** assert rst while byte 5 is presented. tx_valid and busy drop without a clock edge, and pkt_done is not pulsed. After rst is released, a new request produces a complete packet.

Source files
------------

// File: rtl/uart_pack_if.sv
// Byte-stream handshake between the packet builder and the UART transmitter.
interface uart_pack_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, tx_data, input tx_ready);
  modport slave  (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_pack.sv
// Serialises a snapshot of the scaler parameters into a framed packet:
// 00, type, payload, FF, 00, one byte per valid/ready handshake.
module uart_pack #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_req,
  input  logic [3:0]  pkt_type,
  input  logic [15:0] start_x,
  input  logic [15:0] start_y,
  input  logic [15:0] end_x,
  input  logic [15:0] end_y,
  input  logic [15:0] size_x,
  input  logic [15:0] size_y,
  input  logic [7:0]  algorithm,
  uart_pack_if.master tx,
  output logic        busy,
  output logic        pkt_done
);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, HD0, HD1, DATA, END0, END1} state_t;
  state_t state;

  logic [3:0]    s_type;
  logic [15:0]   s_sx, s_sy, s_ex, s_ey, s_zx, s_zy;
  logic [7:0]    s_alg;
  logic [3:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;

  logic       fire;
  logic       short_pkt;
  logic [3:0] pay_len;
  logic [3:0] nxt_idx;
  logic [7:0] pay_byte;

  assign fire      = tx.tx_valid && tx.tx_ready;
  assign short_pkt = (s_type == 4'd1);
  assign pay_len   = short_pkt ? 4'd5 : 4'd9;
  assign nxt_idx   = (state == HD1) ? 4'd1 : byte_cnt + 4'd1;

  // Payload byte that will be presented after the current handshake.
  always_comb begin
    pay_byte = s_alg;
    if (short_pkt) begin
      case (nxt_idx)
        4'd1:    pay_byte = s_zx[15:8];
        4'd2:    pay_byte = s_zx[7:0];
        4'd3:    pay_byte = s_zy[15:8];
        4'd4:    pay_byte = s_zy[7:0];
        default: pay_byte = s_alg;
      endcase
    end else begin
      case (nxt_idx)
        4'd1:    pay_byte = s_sx[15:8];
        4'd2:    pay_byte = s_sx[7:0];
        4'd3:    pay_byte = s_sy[15:8];
        4'd4:    pay_byte = s_sy[7:0];
        4'd5:    pay_byte = s_ex[15:8];
        4'd6:    pay_byte = s_ex[7:0];
        4'd7:    pay_byte = s_ey[15:8];
        4'd8:    pay_byte = s_ey[7:0];
        default: pay_byte = s_alg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      s_type      <= 4'h0;
      s_sx        <= 16'h0;
      s_sy        <= 16'h0;
      s_ex        <= 16'h0;
      s_ey        <= 16'h0;
      s_zx        <= 16'h0;
      s_zy        <= 16'h0;
      s_alg       <= 8'h0;
      byte_cnt    <= 4'd0;
      gap_cnt     <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (state == IDLE) begin
        if (pkt_req) begin
          s_type      <= pkt_type;
          s_sx        <= start_x;
          s_sy        <= start_y;
          s_ex        <= end_x;
          s_ey        <= end_y;
          s_zx        <= size_x;
          s_zy        <= size_y;
          s_alg       <= algorithm;
          state       <= HD0;
          busy        <= 1'b1;
          tx.tx_valid <= 1'b1;
          tx.tx_data  <= 8'h00;
        end
      end else if (fire) begin
        case (state)
          HD0: begin
            tx.tx_data <= {4'h0, s_type};
            state      <= HD1;
          end
          HD1: begin
            tx.tx_data <= pay_byte;
            byte_cnt   <= 4'd1;
            state      <= DATA;
          end
          DATA: begin
            if (byte_cnt == pay_len) begin
              tx.tx_data <= 8'hFF;
              state      <= END0;
            end else begin
              tx.tx_data <= pay_byte;
              byte_cnt   <= nxt_idx;
            end
          end
          END0: begin
            tx.tx_data <= 8'h00;
            state      <= END1;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            pkt_done <= 1'b1;
          end
        endcase
        // The final tail byte is never followed by a gap.
        if (state == END1) begin
          tx.tx_valid <= 1'b0;
        end else if (GAP_CYCLES > 0) begin
          tx.tx_valid <= 1'b0;
          gap_cnt     <= GAP_LOAD;
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
        if (gap_cnt == GW'(1)) tx.tx_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_pack.sv
// Randomised scoreboard bench for uart_pack: a no-gap instance and a
// GAP_CYCLES=3 instance, each with its own expected-byte queue and monitor.
module tb_uart_pack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_req0 = 1'b0, pkt_req3 = 1'b0;
  logic [3:0]  ptype = 4'h0;
  logic [15:0] sx = 16'h0, sy = 16'h0, ex = 16'h0, ey = 16'h0, zx = 16'h0, zy = 16'h0;
  logic [7:0]  alg = 8'h0;
  logic        busy0, done0, busy3, done3;
  logic        bp_en = 1'b0;

  int cyc = 0, pass_cnt = 0, total_cnt = 0, done_cnt0 = 0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];
  int hs3[$];

  uart_pack_if bus0();
  uart_pack_if bus3();

  uart_pack #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .pkt_req(pkt_req0), .pkt_type(ptype),
    .start_x(sx), .start_y(sy), .end_x(ex), .end_y(ey),
    .size_x(zx), .size_y(zy), .algorithm(alg),
    .tx(bus0), .busy(busy0), .pkt_done(done0)
  );

  uart_pack #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .pkt_req(pkt_req3), .pkt_type(ptype),
    .start_x(sx), .start_y(sy), .end_x(ex), .end_y(ey),
    .size_x(zx), .size_y(zy), .algorithm(alg),
    .tx(bus3), .busy(busy3), .pkt_done(done3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference framing built from the field values at request time.
  task automatic expect_pkt(input int which, input logic [3:0] t);
    logic [7:0]  b[$];
    logic [15:0] f[$];
    b.push_back(8'h00);
    b.push_back({4'h0, t});
    if (t == 4'd1) begin
      f.push_back(zx); f.push_back(zy);
    end else begin
      f.push_back(sx); f.push_back(sy); f.push_back(ex); f.push_back(ey);
    end
    foreach (f[i]) begin
      b.push_back(8'(f[i] >> 8));
      b.push_back(8'(f[i] & 16'h00FF));
    end
    b.push_back(alg);
    b.push_back(8'hFF);
    b.push_back(8'h00);
    foreach (b[i]) begin
      if (which == 0) q0.push_back(b[i]);
      else q3.push_back(b[i]);
    end
  endtask

  task automatic issue(input int which, input logic [3:0] t, output int a);
    ptype = t;
    expect_pkt(which, t);
    if (which == 0) pkt_req0 = 1'b1;
    else pkt_req3 = 1'b1;
    @(posedge clk);
    #1;
    pkt_req0 = 1'b0;
    pkt_req3 = 1'b0;
    a = cyc;
  endtask

  task automatic wait_done(input int which, input int bound, output int c);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if ((which == 0) ? done0 : done3) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_t0_fields();
    sx = 16'h0010; sy = 16'h0020; ex = 16'h0780; ey = 16'h0438; alg = 8'h02;
  endtask

  task automatic set_t1_fields();
    zx = 16'h0500; zy = 16'h02D0; alg = 8'h01;
  endtask

  // Ready generator for the no-gap instance.
  initial begin
    bus0.tx_ready = 1'b1;
    bus3.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus0.tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done0) done_cnt0++;
  end

  // Monitor, no-gap instance: byte order plus hold-while-stalled.
  initial begin
    logic       stall_pend;
    logic [7:0] stall_data;
    stall_pend = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          check("stall_valid_hold", 32'(bus0.tx_valid), 32'd1);
          check("stall_data_hold", 32'(bus0.tx_data), 32'(stall_data));
        end
        stall_pend = bus0.tx_valid && !bus0.tx_ready;
        stall_data = bus0.tx_data;
        if (bus0.tx_valid && bus0.tx_ready) begin
          if (q0.size() == 0) begin
            total_cnt++;
            $display("FAIL extra_byte0: got %02h, expected no byte (cycle %0d)", bus0.tx_data, cyc);
          end else begin
            check("byte0", 32'(bus0.tx_data), 32'(q0.pop_front()));
          end
        end
      end
    end
  end

  // Monitor, gap instance: byte order plus handshake cycle log.
  initial forever begin
    @(negedge clk);
    if (!rst && bus3.tx_valid && bus3.tx_ready) begin
      hs3.push_back(cyc);
      if (q3.size() == 0) begin
        total_cnt++;
        $display("FAIL extra_byte3: got %02h, expected no byte (cycle %0d)", bus3.tx_data, cyc);
      end else begin
        check("byte3", 32'(bus3.tx_data), 32'(q3.pop_front()));
      end
    end
  end

  initial begin
    int a, c, d;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus0.tx_valid), 32'd0);
    check("rst_data", 32'(bus0.tx_data), 32'h00);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_valid3", 32'(bus3.tx_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Type 0, then a type 1 requested in the pkt_done cycle.
    set_t0_fields();
    issue(0, 4'd0, a);
    @(negedge clk);
    check("first_valid", 32'(bus0.tx_valid), 32'd1);
    check("first_data", 32'(bus0.tx_data), 32'h00);
    check("first_busy", 32'(busy0), 32'd1);
    wait_done(0, 100, c);
    check("t0_done_cycle", 32'(c - a), 32'd13);
    check("t0_done_busy", 32'(busy0), 32'd0);
    set_t1_fields();
    issue(0, 4'd1, a);
    @(negedge clk);
    check("b2b_valid", 32'(bus0.tx_valid), 32'd1);
    check("b2b_data", 32'(bus0.tx_data), 32'h00);
    check("b2b_busy", 32'(busy0), 32'd1);
    wait_done(0, 100, c);
    check("t1_done_cycle", 32'(c - a), 32'd9);

    // Snapshot: field change and request mid-packet are ignored.
    set_t0_fields();
    d = done_cnt0;
    issue(0, 4'd0, a);
    repeat (3) @(posedge clk);
    #1;
    sx = 16'hBEEF;
    pkt_req0 = 1'b1;
    @(posedge clk);
    #1;
    pkt_req0 = 1'b0;
    wait_done(0, 100, c);
    repeat (10) @(negedge clk);
    check("snap_one_done", 32'(done_cnt0 - d), 32'd1);
    check("snap_queue_empty", 32'(q0.size()), 32'd0);
    check("snap_idle", 32'(busy0), 32'd0);

    // Backpressure on the reference type 0 packet.
    set_t0_fields();
    bp_en = 1'b1;
    issue(0, 4'd0, a);
    wait_done(0, 400, c);

    // Random types and fields, random backpressure.
    for (int i = 0; i < 8; i++) begin
      sx = 16'($urandom); sy = 16'($urandom); ex = 16'($urandom); ey = 16'($urandom);
      zx = 16'($urandom); zy = 16'($urandom); alg = 8'($urandom);
      bp_en = 1'($urandom_range(0, 1));
      issue(0, 4'($urandom_range(0, 15)), a);
      wait_done(0, 400, c);
      check("rand_queue_empty", 32'(q0.size()), 32'd0);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;

    // Reset while byte 5 is presented.
    set_t0_fields();
    issue(0, 4'd0, a);
    repeat (5) @(negedge clk);
    #2;
    d = done_cnt0;
    rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(bus0.tx_valid), 32'd0);
    check("rstmid_busy", 32'(busy0), 32'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt0 - d), 32'd0);
    check("rstmid_idle_valid", 32'(bus0.tx_valid), 32'd0);
    set_t1_fields();
    issue(0, 4'd1, a);
    wait_done(0, 100, c);
    check("rstmid_recover_cycle", 32'(c - a), 32'd9);
    check("rstmid_queue_empty", 32'(q0.size()), 32'd0);

    // Gap instance, type 1.
    hs3.delete();
    set_t1_fields();
    issue(3, 4'd1, a);
    wait_done(3, 200, c);
    check("gap_done_cycle", 32'(c - a), 32'd33);
    check("gap_byte_count", 32'(hs3.size()), 32'd9);
    if (hs3.size() == 9) begin
      check("gap_span", 32'(hs3[8] - a + 1), 32'd33);
      for (int i = 1; i < 9; i++) check("gap_spacing", 32'(hs3[i] - hs3[i-1]), 32'd4);
    end
    check("gap_queue_empty", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
